perf_delay_responder: RTL and testbench
=======================================

# perf_delay_responder

Programmable-latency responder for the bus performance-monitoring environment. It accepts requests on a valid/ready input port and returns one response per request, in order, a configured number of cycles after acceptance. It provides a known, deterministic latency source behind the performance monitor, so measured latencies can be checked against ground truth.

## Interface
Parameters:
- `DEPTH`, 16: maximum outstanding requests. Any integer ≥ 2.
- `CNT_WIDTH`, 16: width of the timestamp counter and of `latency_i`.

Ports:
- `clk_i`, input, 1: clock. All logic is on the rising edge.
- `rst_i`, input, 1: reset, asynchronous, active-high.
- `latency_i`, input, `CNT_WIDTH`: requested response latency in cycles. A value of 0 is treated as 1.
- `req_valid_i`, input, 1: request valid.
- `req_ready_o`, output, 1: request ready; asserted when the queue is not full.
- `rsp_valid_o`, output, 1: response valid.
- `rsp_ready_i`, input, 1: response ready.
- `usage_o`, output, `$clog2(DEPTH+1)`: number of outstanding entries.
- `stall_cnt_o`, output, 32: cycles where `rsp_valid_o && !rsp_ready_i`. See Configuration.

## Operation
- A free-running counter `now` (`CNT_WIDTH` bits) increments every cycle and wraps modulo 2^`CNT_WIDTH`.
- Request accept happens on a cycle with `req_valid_i && req_ready_o`.
  - On accept, push an entry with `deadline = now + max(latency_i,1)` (modular) and `done = 0`.
  - `latency_i` is captured per entry at acceptance. Later changes affect only later requests.
- Every cycle, each valid entry whose `deadline == now` sets `done = 1`.
  - `done` is sticky until the entry is popped.
  - Because `done` is sticky, an entry held behind backpressure longer than 2^`CNT_WIDTH` cycles still stays due. Wrap-around is harmless for any latency ≤ 2^`CNT_WIDTH`−1.
- Output rules:
  - `rsp_valid_o = head valid && (head.done || head.deadline == now)`.
  - Pop happens on a cycle with `rsp_valid_o && rsp_ready_i`.
- Responses are strictly in order. A younger entry that becomes due before the head waits, keeping `done = 1`, and is released on the cycle after the head pops.
- `req_ready_o = (usage_o != DEPTH)`. There is no push-through-when-full: with the queue full, a pop in the same cycle does not enable a push.
- With the queue not full, simultaneous push and pop are both performed, and `usage_o` is unchanged.
- `rsp_valid_o`, once asserted, stays high until the pop. No retraction.
- Queue storage is a circular buffer with read/write pointers and a count. The pointers wrap at `DEPTH`, including non-power-of-two values.

## Timing
- A request accepted in cycle T with latency L ≥ 1 makes `rsp_valid_o` high in cycle T+L at the earliest. It is exactly T+L if the head is free and not stalled.
- With `rsp_ready_i` held high and continuous requests at a fixed L, throughput is one response per cycle.
- While `rst_i` is high:
  - `rsp_valid_o` = 0, `req_ready_o` = 1, `usage_o` = 0, `stall_cnt_o` = 0.
  - `now` = 0 and all entries are invalid.
- Reset asserted mid-operation drops all outstanding entries immediately, asynchronously, with no response emitted for them.
- The first accept is possible in the first cycle after `rst_i` deasserts.

## Configuration
- Macro `PERF_DELAY_RESP_STATS_EN`.
- Defined:
  - `stall_cnt_o` counts cycles with `rsp_valid_o && !rsp_ready_i`.
  - It saturates at 2^32−1 and is cleared only by reset.
- Undefined:
  - The counter logic is not compiled in.
  - `stall_cnt_o` is tied to 0, and the port list is unchanged.

## Test plan
- **Single request.** Reset, `latency_i`=5, one request at cycle 10, `rsp_ready_i`=1 → `rsp_valid_o` high only in cycle 15, `usage_o` back to 0 in cycle 16.
- **Zero latency.** `latency_i`=0, request at cycle T → response in cycle T+1.
- **Full queue.** `DEPTH`=16, `latency_i`=100, 20 back-to-back requests with `rsp_ready_i`=1:
  - `req_ready_o` drops after 16 accepts.
  - `usage_o`=16.
  - The first response comes 100 cycles after the first accept.
  - `req_ready_o` returns high in the cycle after the first pop.
- **In-order release.**
  - Requests A (L=20) at cycle 0 and B (L=2) at cycle 1 → B is not presented before A.
  - A appears in cycle 20, B in cycle 21.
- **Backpressure and wrap.** `CNT_WIDTH`=4, L=3, `rsp_ready_i` low for 40 cycles:
  - `rsp_valid_o` stays high from cycle T+3 and the response is not lost.
  - With `PERF_DELAY_RESP_STATS_EN` defined, `stall_cnt_o` = 37 at release; with it undefined, `stall_cnt_o` = 0.
- **Reset mid-operation.** 5 entries outstanding, pulse `rst_i` for 1 cycle → `usage_o`=0, `rsp_valid_o`=0, no later responses for the dropped entries.

Source files
------------

// File: rtl/perf_delay_responder.sv
// perf_delay_responder
//   Programmable-latency responder. Each accepted request is answered, in order,
//   max(latency_i,1) cycles after acceptance (later if the head is backpressured).
//
// Parameters
//   DEPTH     : maximum outstanding requests (>= 2, any integer)
//   CNT_WIDTH : width of the timestamp counter and latency_i
//
// Ports
//   clk_i        : clock, rising edge
//   rst_i        : asynchronous active-high reset
//   latency_i    : requested latency, sampled per request at acceptance (0 acts as 1)
//   req_valid_i  : request valid
//   req_ready_o  : request ready (queue not full)
//   rsp_valid_o  : response valid (head is due)
//   rsp_ready_i  : response ready
//   usage_o      : number of outstanding entries
//   stall_cnt_o  : saturating count of rsp_valid_o && !rsp_ready_i cycles
//
// Build option
//   PERF_DELAY_RESP_STATS_EN : when defined, the stall counter is built;
//                              otherwise stall_cnt_o is tied to zero.
module perf_delay_responder #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [CNT_WIDTH-1:0]       latency_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] usage_o,
  output logic [31:0]                stall_cnt_o
);

  localparam int unsigned PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned UsageW = $clog2(DEPTH + 1);

  localparam logic [CNT_WIDTH-1:0] CntOne   = CNT_WIDTH'(1);
  localparam logic [UsageW-1:0]    UsageOne = UsageW'(1);
  localparam logic [UsageW-1:0]    UsageMax = UsageW'(DEPTH);
  localparam logic [PtrW-1:0]      PtrOne   = PtrW'(1);
  localparam logic [PtrW-1:0]      PtrLast  = PtrW'(DEPTH - 1);

  logic [CNT_WIDTH-1:0] now_q;
  logic [CNT_WIDTH-1:0] deadline_q [DEPTH];
  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [DEPTH-1:0]     done_q, done_d;
  logic [PtrW-1:0]      rptr_q, rptr_d;
  logic [PtrW-1:0]      wptr_q, wptr_d;
  logic [UsageW-1:0]    count_q, count_d;

  logic                 push;
  logic                 pop;
  logic [CNT_WIDTH-1:0] lat_eff;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrOne;
  endfunction

  assign lat_eff     = (latency_i == '0) ? CntOne : latency_i;
  assign req_ready_o = (count_q != UsageMax);
  assign usage_o     = count_q;
  assign rsp_valid_o = valid_q[rptr_q] && (done_q[rptr_q] || (deadline_q[rptr_q] == now_q));
  assign push        = req_valid_i && req_ready_o;
  assign pop         = rsp_valid_o && rsp_ready_i;

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;

    // done is sticky, so an entry stays due even after the counter wraps past it.
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_q[i] && (deadline_q[i] == now_q)) begin
        done_d[i] = 1'b1;
      end
    end

    if (pop) begin
      valid_d[rptr_q] = 1'b0;
      done_d[rptr_q]  = 1'b0;
      rptr_d          = ptr_inc(rptr_q);
    end

    // Push never targets the head slot being popped: a pop needs count > 0 and
    // a push needs count < DEPTH, so wptr != rptr whenever both happen.
    if (push) begin
      valid_d[wptr_q] = 1'b1;
      done_d[wptr_q]  = 1'b0;
      wptr_d          = ptr_inc(wptr_q);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + UsageOne;
      2'b01:   count_d = count_q - UsageOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      now_q   <= '0;
      valid_q <= '0;
      done_q  <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      now_q   <= now_q + CntOne;
      valid_q <= valid_d;
      done_q  <= done_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Deadline storage needs no reset; valid_q qualifies every use.
  always_ff @(posedge clk_i) begin
    if (push) begin
      deadline_q[wptr_q] <= now_q + lat_eff;
    end
  end

`ifdef PERF_DELAY_RESP_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if (rsp_valid_o && !rsp_ready_i && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_perf_delay_responder.sv
module tb_perf_delay_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // Main instance: DEPTH=16, CNT_WIDTH=16.
  logic [15:0] lat   = '0;
  logic        req_v = 1'b0;
  logic        req_rdy;
  logic        rsp_v;
  logic        rsp_r = 1'b1;
  logic [4:0]  usage;
  logic [31:0] stall;

  // Small instance for counter-wrap test: DEPTH=4, CNT_WIDTH=4.
  logic [3:0]  lat_s   = '0;
  logic        req_v_s = 1'b0;
  logic        req_rdy_s;
  logic        rsp_v_s;
  logic        rsp_r_s = 1'b1;
  logic [2:0]  usage_s;
  logic [31:0] stall_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  perf_delay_responder #(.DEPTH(16), .CNT_WIDTH(16)) u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .latency_i   (lat),
    .req_valid_i (req_v),
    .req_ready_o (req_rdy),
    .rsp_valid_o (rsp_v),
    .rsp_ready_i (rsp_r),
    .usage_o     (usage),
    .stall_cnt_o (stall)
  );

  perf_delay_responder #(.DEPTH(4), .CNT_WIDTH(4)) u_dut_s (
    .clk_i       (clk),
    .rst_i       (rst),
    .latency_i   (lat_s),
    .req_valid_i (req_v_s),
    .req_ready_o (req_rdy_s),
    .rsp_valid_o (rsp_v_s),
    .rsp_ready_i (rsp_r_s),
    .usage_o     (usage_s),
    .stall_cnt_o (stall_s)
  );

  // Start a new cycle: inputs change just after the rising edge, checks at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (rsp_v !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_v); end
    total++; if (req_rdy !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_rdy); end
    total++; if (usage !== 5'd0) begin bad++; $display("FAIL reset_usage got=%0d exp=0", usage); end
    total++; if (stall !== 32'd0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", stall); end
    total++; if ({rsp_v_s, req_rdy_s, usage_s} !== 5'b01000) begin
      bad++; $display("FAIL reset_small got=%b exp=01000", {rsp_v_s, req_rdy_s, usage_s});
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_single();
    logic exp;
    tick(); lat = 16'd5; req_v = 1'b1;
    @(negedge clk);
    total++; if (req_rdy !== 1'b1) begin bad++; $display("FAIL single_ready got=%b exp=1", req_rdy); end
    for (int k = 1; k <= 6; k++) begin
      tick(); req_v = 1'b0;
      @(negedge clk);
      exp = (k == 5);
      total++; if (rsp_v !== exp) begin
        bad++; $display("FAIL single_rsp_valid k=%0d got=%b exp=%b", k, rsp_v, exp);
      end
      if (k == 1) begin
        total++; if (usage !== 5'd1) begin bad++; $display("FAIL single_usage1 got=%0d exp=1", usage); end
      end
      if (k == 6) begin
        total++; if (usage !== 5'd0) begin bad++; $display("FAIL single_usage_end got=%0d exp=0", usage); end
      end
    end
  endtask

  task automatic test_zero_latency();
    tick(); lat = 16'd0; req_v = 1'b1;
    tick(); req_v = 1'b0;
    @(negedge clk);
    total++; if (rsp_v !== 1'b1) begin bad++; $display("FAIL zero_lat_rsp got=%b exp=1", rsp_v); end
    tick();
    @(negedge clk);
    total++; if ({rsp_v, usage} !== 6'b0_00000) begin
      bad++; $display("FAIL zero_lat_after got=%b exp=000000", {rsp_v, usage});
    end
  endtask

  task automatic test_back_to_back();
    logic exp;
    for (int k = 0; k <= 11; k++) begin
      tick(); lat = 16'd3; req_v = (k < 8);
      @(negedge clk);
      exp = (k >= 3) && (k <= 10);
      total++; if (rsp_v !== exp) begin
        bad++; $display("FAIL b2b_rsp_valid k=%0d got=%b exp=%b", k, rsp_v, exp);
      end
    end
    req_v = 1'b0;
    total++; if (usage !== 5'd0) begin bad++; $display("FAIL b2b_usage got=%0d exp=0", usage); end
  endtask

  task automatic test_full();
    logic       e_rdy, e_rsp;
    logic [4:0] e_use;
    bit         drained;
    for (int c = 0; c <= 104; c++) begin
      tick(); lat = 16'd100; req_v = 1'b1;
      @(negedge clk);
      e_rdy = (c < 16) || (c >= 101);
      e_rsp = (c >= 100);
      e_use = (c <= 16) ? 5'(c) : ((c <= 100) ? 5'd16 : 5'd15);
      if (req_rdy !== e_rdy) begin
        bad++; $display("FAIL full_ready c=%0d got=%b exp=%b", c, req_rdy, e_rdy);
      end
      if (rsp_v !== e_rsp) begin
        bad++; $display("FAIL full_rsp_valid c=%0d got=%b exp=%b", c, rsp_v, e_rsp);
      end
      if (usage !== e_use) begin
        bad++; $display("FAIL full_usage c=%0d got=%0d exp=%0d", c, usage, e_use);
      end
      total += 3;
    end
    req_v = 1'b0;
    drained = 1'b0;
    for (int c = 0; c < 300 && !drained; c++) begin
      tick();
      @(negedge clk);
      if (usage == 5'd0 && !rsp_v) drained = 1'b1;
    end
    total++; if (!drained) begin bad++; $display("FAIL full_drain got=usage%0d exp=usage0", usage); end
  endtask

  task automatic test_in_order();
    logic exp;
    tick(); lat = 16'd20; req_v = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      tick(); lat = 16'd2; req_v = (k == 1);
      @(negedge clk);
      exp = (k == 20) || (k == 21);
      total++; if (rsp_v !== exp) begin
        bad++; $display("FAIL in_order_rsp k=%0d got=%b exp=%b", k, rsp_v, exp);
      end
    end
    total++; if (usage !== 5'd0) begin bad++; $display("FAIL in_order_usage got=%0d exp=0", usage); end
  endtask

  task automatic test_backpressure_wrap();
    logic        exp;
    logic [31:0] exp_stall;
`ifdef PERF_DELAY_RESP_STATS_EN
    exp_stall = 32'd37;
`else
    exp_stall = 32'd0;
`endif
    tick(); lat_s = 4'd3; req_v_s = 1'b1; rsp_r_s = 1'b0;
    for (int k = 1; k <= 39; k++) begin
      tick(); req_v_s = 1'b0;
      @(negedge clk);
      exp = (k >= 3);
      if (rsp_v_s !== exp) begin
        bad++; $display("FAIL bp_rsp_valid k=%0d got=%b exp=%b", k, rsp_v_s, exp);
      end
      total++;
    end
    tick(); rsp_r_s = 1'b1;
    @(negedge clk);
    total++; if (rsp_v_s !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", rsp_v_s); end
    total++; if (stall_s !== exp_stall) begin
      bad++; $display("FAIL bp_stall_cnt got=%0d exp=%0d", stall_s, exp_stall);
    end
    tick();
    @(negedge clk);
    total++; if ({rsp_v_s, usage_s, req_rdy_s} !== 5'b0_000_1) begin
      bad++; $display("FAIL bp_after got=%b exp=00001", {rsp_v_s, usage_s, req_rdy_s});
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    for (int k = 0; k < 5; k++) begin
      tick(); lat = 16'd30; req_v = 1'b1;
    end
    tick(); req_v = 1'b0;
    @(negedge clk);
    total++; if (usage !== 5'd5) begin bad++; $display("FAIL mid_usage_before got=%0d exp=5", usage); end
    tick(); rst = 1'b1;
    @(negedge clk);
    total++; if ({rsp_v, usage} !== 6'd0) begin
      bad++; $display("FAIL mid_in_reset got=%b exp=000000", {rsp_v, usage});
    end
    tick(); rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick();
      @(negedge clk);
      if (rsp_v || usage != 5'd0) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL mid_no_late_rsp got=activity exp=none"); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero_latency();
    test_back_to_back();
    test_full();
    test_in_order();
    test_backpressure_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
